// File: rtl/lru_grant_scheduler.sv
// LRU arbiter: grants one requester at a time, least-recently-used first.
// Define LRU_TIMEOUT_EN to enable tick-counted forced release (timeout).
module lru_grant_scheduler #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_TICKS = 3,
  localparam int unsigned ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            tick,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            timeout,
  output logic [ID_W-1:0] lru_id
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] cur_q, cur_d;
  logic [ID_W-1:0] order_q [N];
  logic [ID_W-1:0] order_d [N];
  logic [ID_W-1:0] mru     [N];
  logic [ID_W-1:0] win;
  int              pos;

`ifdef LRU_TIMEOUT_EN
  localparam logic [7:0] TickLast = 8'(MAX_TICKS - 1);
  logic [7:0] tcnt_q, tcnt_d;
  logic       timeout_q, timeout_d;
`else
  logic unused_tick;
  assign unused_tick = tick;
`endif

  // Scan from MRU down so the lowest-position active requester wins.
  always_comb begin
    win = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req[order_q[k]]) win = order_q[k];
    end
  end

  // Order with cur removed from its slot and appended at the MRU end.
  always_comb begin
    pos = 0;
    for (int k = 0; k < int'(N); k++) begin
      if (order_q[k] == cur_q) pos = k;
    end
    for (int k = 0; k < int'(N) - 1; k++) begin
      mru[k] = (k < pos) ? order_q[k] : order_q[k+1];
    end
    mru[N-1] = cur_q;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    order_d = order_q;
`ifdef LRU_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          cur_d   = win;
`ifdef LRU_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      StGrant: begin
        if (!req[cur_q]) begin
          state_d = StIdle;
          order_d = mru;
        end
`ifdef LRU_TIMEOUT_EN
        else if (tick && tcnt_q == TickLast) begin
          state_d   = StIdle;
          order_d   = mru;
          timeout_d = 1'b1;
        end else if (tick) begin
          tcnt_d = tcnt_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      for (int k = 0; k < int'(N); k++) order_q[k] <= ID_W'(k);
`ifdef LRU_TIMEOUT_EN
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      order_q <= order_d;
`ifdef LRU_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == StGrant) grant[cur_q] = 1'b1;
  end

  assign busy     = (state_q == StGrant);
  assign grant_id = busy ? cur_q : '0;
  assign lru_id   = order_q[0];
`ifdef LRU_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_lru_grant_scheduler.sv
// Directed bench for lru_grant_scheduler (N=4, MAX_TICKS=3); follows LRU_TIMEOUT_EN.
module tb_lru_grant_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       tick;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  logic [1:0] lru_id;

  int total  = 0;
  int passed = 0;

  lru_grant_scheduler #(
    .N         (4),
    .MAX_TICKS (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .tick     (tick),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout),
    .lru_id   (lru_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] gid,
                           input logic b, input logic t, input logic [1:0] l);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
    check({tag, ".lru_id"}, 32'(lru_id), 32'(l));
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; tick = 1'b0;
    step(); step();
    rst = 1'b0;
    check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

    req = 4'b1111;
    step();
    check_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);

    // Release of 0: order becomes {1,2,3,0}
    req = 4'b1110;
    step();
    check_all("release0_gap", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1);
    step();
    check_all("grant1", 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1);

    // Release of 1: order becomes {2,3,0,1}
    req = 4'b1100;
    step();
    check_all("release1_gap", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd2);
    step();
    check_all("grant2", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2);

    // Reset mid-grant restores order {0,1,2,3}
    rst = 1'b1;
    step();
    check_all("reset_mid", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    req = 4'b1010;
    step();
    check_all("post_reset_win1", 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);

    // Release 1: order {0,2,3,1}; sole requester 3 wins
    req = 4'b1000;
    step();
    check_all("release1b_gap", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    step();
    check_all("grant3", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);

    // Non-granted requester changes are ignored during GRANT
    req = 4'b1011;
    step();
    check_all("ignore_others", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    req = 4'b1000;

`ifdef LRU_TIMEOUT_EN
    tick = 1'b1; step(); tick = 1'b0;
    check_all("tick1", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    step();
    tick = 1'b1; step(); tick = 1'b0;
    check_all("tick2", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    step();
    tick = 1'b1; step(); tick = 1'b0;
    check_all("timeout_edge", 4'b0000, 2'd0, 1'b0, 1'b1, 2'd0);
    step();
    check_all("regrant3", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    // Third tick coincides with req drop: voluntary release, no timeout
    tick = 1'b1; step(); tick = 1'b0;
    step();
    tick = 1'b1; step(); tick = 1'b0;
    check_all("tick2b", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    step();
    req = 4'b0000; tick = 1'b1;
    step();
    tick = 1'b0;
    check_all("drop_and_tick", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
`else
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      check_all("hold_tick", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
      step();
    end
    req = 4'b0000;
    step();
    check_all("release3", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
`endif

    // Idle with no requests holds; ticks in IDLE are ignored
    tick = 1'b1; step(); tick = 1'b0;
    check_all("idle_hold", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

    // Order is now {0,2,1,3}: 2 beats 1
    req = 4'b0110;
    step();
    check_all("lru_2_over_1", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);

    // Release 2: order {0,1,3,2}; 1 then wins over 2
    req = 4'b0010;
    step();
    check_all("release2", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    req = 4'b0110;
    step();
    check_all("lru_1_over_2", 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lru_grant_scheduler.md
Name: lru_grant_scheduler

Overview:
- Shares one resource among N requesters using least-recently-used priority.
- Grant length is bounded by counting pulses on a periodic tick input, normally driven by the team's timer block.
- Sits between the request sources and the shared resource.
- Outputs a one-hot grant, its encoded index, and the current LRU ordering head for debug displays.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_TICKS, 3, tick pulses a grant may last before forced release (1..255).
- ID_W, $clog2(N), width of encoded requester index; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- req  input  N  per-requester request, level; held high while resource is wanted.
- tick  input  1  single-cycle periodic pulse from the timer.
- grant  output  N  one-hot grant, registered; all zero when idle.
- grant_id  output  ID_W  index of granted requester; 0 when idle.
- busy  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly released.
- lru_id  output  ID_W  requester at LRU position (order[0]).

Behaviour:
- State: order[0..N-1], a permutation of 0..N-1. order[0] is the LRU requester; order[N-1] is the MRU requester.
- FSM states: IDLE and GRANT. An ID_W register cur holds the granted index. An 8-bit register tcnt counts ticks.
- Reset:
  - state=IDLE, order[k]=k, tcnt=0, cur=0.
  - grant=0, grant_id=0, busy=0, timeout=0, lru_id=0.
  - Reset mid-grant drops the grant on the next edge; no order update occurs.
- IDLE with req != 0 at edge t:
  - Winner = first order[k] (lowest k) with req[order[k]]=1.
  - At t+1: grant=onehot(winner), grant_id=winner, busy=1, state=GRANT, tcnt=0.
- IDLE with req == 0: hold all outputs; order is unchanged.
- GRANT, at each edge, in priority order:
  - Voluntary release: req[cur]=0. Go to IDLE, move cur to MRU, timeout=0.
  - Timeout: tick=1 and tcnt==MAX_TICKS-1. Go to IDLE, move cur to MRU, timeout=1 for one cycle.
  - Count: tick=1 otherwise. tcnt <= tcnt+1.
  - Changes to req of non-granted requesters are ignored while in GRANT.
- Simultaneous req[cur] drop and timeout tick on the same edge: treated as voluntary release; timeout stays 0.
- Release has one-cycle latency:
  - grant/busy are 0 on the cycle after the release edge.
  - Arbitration happens in that IDLE cycle.
  - The next grant appears 2 cycles after the release edge. Minimum gap between grants is 1 idle cycle.
- Move-to-MRU: remove cur from its position p, shift order[p+1..N-1] down by one, write cur into order[N-1]. Done in one cycle.
- A preempted requester still holding req competes again normally from the MRU position. It is re-granted only if no other requester is active.
- lru_id always reflects the registered order[0].
- tick pulses in IDLE are ignored.

Optional Feature:
- Macro: LRU_TIMEOUT_EN.
- Defined: the tick/tcnt/MAX_TICKS preemption is active as described above.
- Not defined:
  - tcnt logic is removed.
  - A grant lasts until req[cur] drops.
  - The timeout output is tied to 0.
  - The tick input is unused.
  - The LRU update on voluntary release is unchanged.

Test Plan:
- Reset, then req=4'b1111 → grant=0001, grant_id=0, busy=1 one cycle later.
- Drop req[0] → next cycle grant=0000. Cycle after that, grant=0010. After the update, lru_id=1 and order={1,2,3,0}.
- req=4'b1000 held, MAX_TICKS=3, 3 tick pulses in GRANT:
  - timeout=1 for exactly one cycle after the third tick.
  - grant=0 for 1 cycle, then grant=1000 again (sole requester).
- With LRU_TIMEOUT_EN, req[cur] drop and the third tick on the same edge → timeout stays 0; normal release.
- Assert rst while grant=0100 → grant=0, busy=0, order={0,1,2,3}, lru_id=0 on the next cycle.
- Without LRU_TIMEOUT_EN, hold req=0001 through 10 ticks → grant stays 0001 and timeout never asserts.
